// File: rtl/fetch_issue_unit.sv
// Fetch/issue front end: owns the PC, handshakes with instruction memory and queues words for decode.
// Optional: define FETCH_ALIGN_CHK_EN to trap odd redirect targets (sticky err, unit halts).
module fetch_issue_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          QDEPTH   = 2,
  parameter logic [15:0] NOP_WORD = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_done,
  input  logic [15:0] imem_data,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc_inc,
  output logic        halted,
  output logic        err
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  typedef enum logic [1:0] {S_FETCH = 2'd0, S_DROP = 2'd1, S_HALT = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [15:0]   pc, pc_inc, drop_addr, tgt_pc;
  logic [15:0]   q_word  [QDEPTH];
  logic [15:0]   q_pcinc [QDEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          deq, enq, misalign, is_halt_op;

  assign pc_inc     = pc + 16'd2;
  assign is_halt_op = (imem_data[15:11] == 5'b00000);

`ifdef FETCH_ALIGN_CHK_EN
  logic err_q;
  assign tgt_pc   = redirect_pc;
  assign misalign = redirect && redirect_pc[0];
  always_ff @(posedge clk) begin
    if (rst)           err_q <= 1'b0;
    else if (misalign) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign tgt_pc   = redirect_pc & 16'hFFFE;
  assign misalign = 1'b0;
  assign err      = 1'b0;
`endif

  assign instr_valid  = !rst && (count != '0);
  assign deq          = instr_valid && instr_ready;
  assign enq          = (state == S_FETCH) && imem_req && imem_done && !redirect;
  assign instr        = instr_valid ? q_word[rd_ptr]  : NOP_WORD;
  assign instr_pc_inc = instr_valid ? q_pcinc[rd_ptr] : 16'h0000;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Redirect overrides everything; an unanswered request must be drained before refetching.
  always_comb begin
    state_nxt = state;
    if (redirect) begin
      if (misalign)                   state_nxt = S_HALT;
      else if (imem_req && !imem_done) state_nxt = S_DROP;
      else                            state_nxt = S_FETCH;
    end else begin
      case (state)
        S_FETCH: if (enq && is_halt_op) state_nxt = S_HALT;
        S_DROP:  if (imem_done)         state_nxt = S_FETCH;
        default: ;
      endcase
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = (state == S_DROP) ? drop_addr : pc;
    halted    = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: imem_req = (count != QFULL) || deq;
        S_DROP:  imem_req = 1'b1;
        S_HALT:  halted   = (count == '0);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      if (!misalign) pc <= tgt_pc;
    end else begin
      if (enq) begin
        pc     <= pc_inc;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      if (enq && !deq)      count <= count + CW'(1);
      else if (deq && !enq) count <= count - CW'(1);
    end
  end

  // Queue storage and the abandoned fetch address carry no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_word[wr_ptr]  <= imem_data;
      q_pcinc[wr_ptr] <= pc_inc;
    end
    if (redirect && state == S_FETCH && imem_req && !imem_done) drop_addr <= pc;
  end

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Bench for fetch_issue_unit: directed scenarios plus randomized traffic against a queue-level model.
module tb_fetch_issue_unit;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          QDEPTH   = 2;
  localparam logic [15:0] NOP_WORD = 16'h0800;
  localparam int M_FETCH = 0, M_DROP = 1, M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_done, redirect, instr_ready, instr_valid, halted, err;
  logic [15:0] imem_addr, imem_data, redirect_pc, instr, instr_pc_inc;

  fetch_issue_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH), .NOP_WORD(NOP_WORD)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_done(imem_done), .imem_data(imem_data), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_ready(instr_ready), .instr_valid(instr_valid),
    .instr(instr), .instr_pc_inc(instr_pc_inc), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] w; logic [15:0] pinc;} ent_t;

  int          checks = 0, failures = 0;
  int          mem_lat = 0, mem_wait = 0;
  bit          lat_rand = 1'b0;
  logic [15:0] halt_addr = 16'hFFFF;
  ent_t        q[$];
  int          mode = M_FETCH;
  logic [15:0] fpc = RESET_PC, stale_addr = 16'h0000;
  logic        exp_err = 1'b0;
  logic        s_req, s_done, s_valid, s_halted, s_err;
  logic [15:0] s_addr, s_instr, s_pcinc;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == halt_addr) return 16'h0000;
    return 16'h4000 + {1'b0, a[15:1]} + 16'd1;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    repeat (n) begin
      #1 imem_done = 1'b0;
      #1 chk1("req_in_reset", imem_req, 1'b0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    q.delete(); mode = M_FETCH; fpc = RESET_PC; exp_err = 1'b0; mem_wait = 0;
  endtask

  // One clock: drive inputs, let memory answer, compare against the model, advance the model.
  task automatic step(input logic rdy, input logic rd, input logic [15:0] rpc);
    logic deq, ereq, mis;
    logic [15:0] tgt;
    ent_t e;
    instr_ready = rdy; redirect = rd; redirect_pc = rpc;
    #1;
    if (imem_req && mem_wait >= mem_lat) begin
      imem_done = 1'b1; imem_data = mem_word(imem_addr);
    end else begin
      imem_done = 1'b0; imem_data = 16'($urandom);
    end
    #1;
    s_req = imem_req; s_done = imem_done; s_valid = instr_valid; s_halted = halted;
    s_err = err; s_addr = imem_addr; s_instr = instr; s_pcinc = instr_pc_inc;

    chk1("instr_valid", instr_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk16("instr", instr, q[0].w);
      chk16("instr_pc_inc", instr_pc_inc, q[0].pinc);
    end else begin
      chk16("instr_nop", instr, NOP_WORD);
      chk16("instr_pc_inc_empty", instr_pc_inc, 16'h0000);
    end
    deq = (q.size() != 0) && rdy;
    case (mode)
      M_FETCH: ereq = (q.size() < QDEPTH) || deq;
      M_DROP:  ereq = 1'b1;
      default: ereq = 1'b0;
    endcase
    chk1("imem_req", imem_req, ereq);
    if (ereq) chk16("imem_addr", imem_addr, (mode == M_DROP) ? stale_addr : fpc);
    chk1("halted", halted, (mode == M_HALT) && (q.size() == 0));
    chk1("err", err, exp_err);

    if (rd) begin
      tgt = rpc & 16'hFFFE; mis = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
      tgt = rpc; mis = rpc[0];
`endif
      q.delete();
      if (mis) begin
        exp_err = 1'b1; mode = M_HALT;
      end else begin
        if (ereq && !imem_done) begin
          if (mode != M_DROP) stale_addr = fpc;
          mode = M_DROP;
        end else begin
          mode = M_FETCH;
        end
        fpc = tgt;
      end
    end else begin
      if (deq) void'(q.pop_front());
      if (mode == M_FETCH && ereq && imem_done) begin
        e.w = imem_data; e.pinc = fpc + 16'd2;
        q.push_back(e);
        fpc = fpc + 16'd2;
        if (imem_data[15:11] == 5'b00000) mode = M_HALT;
      end else if (mode == M_DROP && imem_done) begin
        mode = M_FETCH;
      end
    end

    if (s_req && !s_done) mem_wait++;
    else begin
      mem_wait = 0;
      if (lat_rand) mem_lat = $urandom_range(0, 3);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] r;
    logic        rd, rdy;
    logic [15:0] rpc;
    rst = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    imem_done = 1'b0; imem_data = 16'h0000;

    // Reset, then single-cycle memory streaming
    do_reset(2);
    step(1, 0, 0);
    chk16("rst_instr", s_instr, NOP_WORD); chk16("rst_pcinc", s_pcinc, 16'h0000);
    chk1("rst_valid", s_valid, 1'b0); chk1("rst_halted", s_halted, 1'b0); chk1("rst_err", s_err, 1'b0);
    chk1("t1_req0", s_req, 1'b1); chk16("t1_addr0", s_addr, 16'h0000);
    step(1, 0, 0);
    chk1("t1_valid1", s_valid, 1'b1); chk16("t1_instr1", s_instr, 16'h4001);
    chk16("t1_pcinc1", s_pcinc, 16'h0002); chk16("t1_addr1", s_addr, 16'h0002);
    step(1, 0, 0);
    chk16("t1_instr2", s_instr, 16'h4002); chk16("t1_pcinc2", s_pcinc, 16'h0004); chk16("t1_addr2", s_addr, 16'h0004);
    step(1, 0, 0);
    chk16("t1_instr3", s_instr, 16'h4003); chk16("t1_pcinc3", s_pcinc, 16'h0006);

    // Decode stall fills the queue
    repeat (5) step(0, 0, 0);
    chk1("t2_req_full", s_req, 1'b0); chk1("t2_valid_full", s_valid, 1'b1);
    step(1, 0, 0);
    chk16("t2_instr_a", s_instr, 16'h4004); chk16("t2_pcinc_a", s_pcinc, 16'h0008);
    chk1("t2_req_on_deq", s_req, 1'b1); chk16("t2_addr_on_deq", s_addr, 16'h000A);
    step(1, 0, 0);
    chk16("t2_instr_b", s_instr, 16'h4005);
    step(1, 0, 0);
    chk16("t2_instr_c", s_instr, 16'h4006); chk16("t2_pcinc_c", s_pcinc, 16'h000C);

    // Slow memory, redirect while a request is outstanding
    do_reset(1); mem_lat = 3;
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 16'h0100);
    chk1("t3_req_at_redirect", s_req, 1'b1); chk1("t3_done_at_redirect", s_done, 1'b0);
    step(1, 0, 0);
    chk16("t3_drop_addr", s_addr, 16'h0000); chk1("t3_drop_done", s_done, 1'b1); chk1("t3_drop_valid", s_valid, 1'b0);
    mem_lat = 0;
    step(1, 0, 0);
    chk16("t3_new_addr", s_addr, 16'h0100); chk1("t3_no_stale", s_valid, 1'b0);
    step(1, 0, 0);
    chk16("t3_first_new", s_instr, 16'h4081); chk16("t3_first_pcinc", s_pcinc, 16'h0102);

    // HALT opcode at 0x0006
    do_reset(1); halt_addr = 16'h0006;
    repeat (4) step(1, 0, 0);
    step(1, 0, 0);
    chk1("t4_no_req_8", s_req, 1'b0); chk16("t4_halt_word", s_instr, 16'h0000);
    chk16("t4_halt_pcinc", s_pcinc, 16'h0008); chk1("t4_not_yet_halted", s_halted, 1'b0);
    step(1, 0, 0);
    chk1("t4_halted", s_halted, 1'b1); chk1("t4_req_idle", s_req, 1'b0);
    step(1, 0, 0);
    step(1, 1, 16'h0020);
    chk1("t4_halted_hold", s_halted, 1'b1);
    halt_addr = 16'hFFFF;
    step(1, 0, 0);
    chk1("t4_resume_req", s_req, 1'b1); chk16("t4_resume_addr", s_addr, 16'h0020); chk1("t4_halt_clr", s_halted, 1'b0);
    step(1, 0, 0);
    chk16("t4_resume_instr", s_instr, 16'h4011); chk16("t4_resume_pcinc", s_pcinc, 16'h0022);

    // Redirect coinciding with dequeue and done
    step(1, 1, 16'h0200);
    chk1("t5_valid_at_redirect", s_valid, 1'b1); chk1("t5_done_at_redirect", s_done, 1'b1);
    step(1, 0, 0);
    chk1("t5_flushed", s_valid, 1'b0); chk16("t5_addr", s_addr, 16'h0200);
    step(1, 0, 0);
    chk16("t5_instr", s_instr, 16'h4101); chk16("t5_pcinc", s_pcinc, 16'h0202);

    // PC wrap
    step(1, 1, 16'hFFFC);
    step(1, 0, 0);
    chk16("t6_addr_fffc", s_addr, 16'hFFFC);
    step(1, 0, 0);
    chk16("t6_instr_fffc", s_instr, 16'hBFFF); chk16("t6_pcinc_fffe", s_pcinc, 16'hFFFE);
    step(1, 0, 0);
    chk16("t6_instr_fffe", s_instr, 16'hC000); chk16("t6_pcinc_wrap", s_pcinc, 16'h0000);
    chk16("t6_addr_wrap", s_addr, 16'h0000);

    // Odd redirect target
    step(1, 1, 16'h0031);
`ifdef FETCH_ALIGN_CHK_EN
    step(1, 0, 0);
    chk1("t7_err", s_err, 1'b1); chk1("t7_halted", s_halted, 1'b1); chk1("t7_req", s_req, 1'b0);
    step(1, 0, 0);
    chk1("t7_err_sticky", s_err, 1'b1);
    do_reset(1);
    step(1, 0, 0);
    chk1("t7_err_rst", s_err, 1'b0); chk1("t7_halted_rst", s_halted, 1'b0); chk16("t7_addr_rst", s_addr, 16'h0000);
`else
    step(1, 0, 0);
    chk1("t7_err_tied", s_err, 1'b0); chk16("t7_addr_forced_even", s_addr, 16'h0030);
    step(1, 0, 0);
    chk16("t7_instr", s_instr, 16'h4019); chk16("t7_pcinc", s_pcinc, 16'h0032);
`endif

    // Randomized traffic: ready, latency, redirects, halts and occasional resets
    lat_rand = 1'b1; mem_lat = $urandom_range(0, 3);
    for (int i = 0; i < 800; i++) begin
      r = $urandom;
      if (r[7:0] < 8'd3) begin
        do_reset(1);
        continue;
      end
      rdy = (r[11:8] < 4'd11);
      rd  = (r[16:12] == 5'd0);
      rpc = {r[31:17], (r[7:0] > 8'd245)};
      if (rd) begin
        if (r[21]) halt_addr = {rpc[15:1], 1'b0} + {12'd0, r[20:18], 1'b0};
        else       halt_addr = 16'hFFFF;
      end
      step(rdy, rd, rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
